// File: rtl/keypad_lock_ctrl.sv
// Keypad code-lock controller: CODE_LEN-digit entry compared against a stored code,
// with auto-relock, failed-attempt lockout, entry inactivity timeout and confirmed code change.
module keypad_lock_ctrl #(
  parameter int          CODE_LEN     = 4,
  parameter logic [31:0] DEFAULT_CODE = 32'h0000_2432,
  parameter int          MAX_FAILS    = 3,
  parameter int          OPEN_CYC     = 1000,
  parameter int          PENALTY_CYC  = 5000,
  parameter int          ENTRY_CYC    = 3000
) (
  input  logic                  clk,
  input  logic                  reset_1,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic                  lock_open,
  output logic                  change_mode,
  output logic                  penalty,
  output logic                  ok_pulse,
  output logic                  err_pulse,
  output logic [3:0]            fail_cnt,
  output logic [3:0]            digit_cnt,
  output logic [CODE_LEN*4-1:0] disp_data
);

  localparam int W  = CODE_LEN * 4;
  localparam int OW = $clog2(OPEN_CYC);
  localparam int PW = $clog2(PENALTY_CYC);
  localparam int EW = $clog2(ENTRY_CYC);
  localparam logic [OW-1:0] OPEN_LAST  = OW'(OPEN_CYC - 1);
  localparam logic [PW-1:0] PEN_LAST   = PW'(PENALTY_CYC - 1);
  localparam logic [EW-1:0] ENTRY_LAST = EW'(ENTRY_CYC - 1);
  localparam logic [OW-1:0] OPEN_ONE   = OW'(1);
  localparam logic [PW-1:0] PEN_ONE    = PW'(1);
  localparam logic [EW-1:0] ENTRY_ONE  = EW'(1);
  localparam logic [3:0]    LEN4       = 4'(CODE_LEN);
  localparam logic [3:0]    MAXF4      = 4'(MAX_FAILS);

  typedef enum logic [2:0] {
    ST_LOCKED  = 3'd0,
    ST_OPEN    = 3'd1,
    ST_PENALTY = 3'd2,
    ST_NEW1    = 3'd3,
    ST_NEW2    = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [W-1:0]  buf_r, buf_s, stored_r, stored_s, pending_r, pending_s;
  logic [3:0]    cnt_r, cnt_s, fail_r, fail_s, fail_inc_s;
  logic          ovf_r, ovf_s;
  logic [OW-1:0] open_tmr_r, open_tmr_s;
  logic [PW-1:0] pen_tmr_r, pen_tmr_s;
  logic [EW-1:0] idle_tmr_r, idle_tmr_s;
  logic          lock_open_r, change_mode_r, penalty_r, ok_r, err_r;
  logic          ok_s, err_s, chg_s;
  logic          open_exp_s, pen_exp_s, idle_run_s, idle_exp_s;
  logic          key_s, is_digit_s, is_enter_s, valid_sub_s, match_code_s, match_pend_s;

  assign open_exp_s   = (state_r == ST_OPEN) && (open_tmr_r == OPEN_LAST);
  assign pen_exp_s    = (state_r == ST_PENALTY) && (pen_tmr_r == PEN_LAST);
  assign idle_run_s   = (cnt_r != 4'd0) || (state_r == ST_NEW1) || (state_r == ST_NEW2);
  assign idle_exp_s   = idle_run_s && (idle_tmr_r == ENTRY_LAST);
  assign key_s        = key_valid && (key_code <= 4'hB) && (state_r != ST_PENALTY);
  assign is_digit_s   = (key_code <= 4'd9);
  assign is_enter_s   = (key_code == 4'hA);
  assign valid_sub_s  = (cnt_r == LEN4) && !ovf_r;
  assign match_code_s = valid_sub_s && (buf_r == stored_r);
  assign match_pend_s = valid_sub_s && (buf_r == pending_r);
  assign fail_inc_s   = (fail_r == 4'hF) ? 4'hF : fail_r + 4'd1;

  // Next-state decision: timer expiries take priority over a key in the same cycle.
  always_comb begin
    state_s    = state_r;
    buf_s      = buf_r;
    cnt_s      = cnt_r;
    ovf_s      = ovf_r;
    fail_s     = fail_r;
    stored_s   = stored_r;
    pending_s  = pending_r;
    ok_s       = 1'b0;
    err_s      = 1'b0;
    open_tmr_s = (state_r == ST_OPEN) ? open_tmr_r + OPEN_ONE : {OW{1'b0}};
    pen_tmr_s  = (state_r == ST_PENALTY) ? pen_tmr_r + PEN_ONE : {PW{1'b0}};
    idle_tmr_s = idle_run_s ? idle_tmr_r + ENTRY_ONE : {EW{1'b0}};
    if (pen_exp_s) begin
      state_s = ST_LOCKED;
      fail_s  = 4'd0;
    end else if (open_exp_s) begin
      state_s = ST_LOCKED;
    end else if (idle_exp_s) begin
      buf_s      = {W{1'b0}};
      cnt_s      = 4'd0;
      ovf_s      = 1'b0;
      idle_tmr_s = {EW{1'b0}};
      state_s    = (state_r == ST_NEW1 || state_r == ST_NEW2) ? ST_LOCKED : state_r;
    end else if (key_s) begin
      idle_tmr_s = {EW{1'b0}};
      if (is_digit_s) begin
        if (cnt_r == LEN4) begin
          ovf_s = 1'b1;
        end else begin
          buf_s = W'({buf_r, key_code});
          cnt_s = cnt_r + 4'd1;
        end
      end else begin
        buf_s = {W{1'b0}};
        cnt_s = 4'd0;
        ovf_s = 1'b0;
        case (state_r)
          ST_LOCKED: begin
            if (match_code_s) begin
              ok_s    = 1'b1;
              fail_s  = 4'd0;
              state_s = is_enter_s ? ST_OPEN : ST_NEW1;
            end else begin
              err_s   = 1'b1;
              fail_s  = fail_inc_s;
              state_s = (fail_inc_s == MAXF4) ? ST_PENALTY : ST_LOCKED;
            end
          end
          ST_OPEN: state_s = is_enter_s ? ST_LOCKED : ST_OPEN;
          ST_NEW1: begin
            if (!is_enter_s) begin
              state_s = ST_LOCKED;
            end else if (valid_sub_s) begin
              pending_s = buf_r;
              state_s   = ST_NEW2;
            end else begin
              err_s = 1'b1;
            end
          end
          ST_NEW2: begin
            if (!is_enter_s) begin
              state_s = ST_LOCKED;
            end else if (match_pend_s) begin
              stored_s = pending_r;
              ok_s     = 1'b1;
              state_s  = ST_LOCKED;
            end else begin
              err_s   = 1'b1;
              state_s = ST_NEW1;
            end
          end
          default: state_s = ST_LOCKED;
        endcase
      end
    end else begin
      state_s = state_r;
    end
    // Any state change discards the entry and restarts every timer.
    chg_s      = (state_s != state_r);
    buf_s      = chg_s ? {W{1'b0}} : buf_s;
    cnt_s      = chg_s ? 4'd0 : cnt_s;
    ovf_s      = chg_s ? 1'b0 : ovf_s;
    idle_tmr_s = chg_s ? {EW{1'b0}} : idle_tmr_s;
    open_tmr_s = chg_s ? {OW{1'b0}} : open_tmr_s;
    pen_tmr_s  = chg_s ? {PW{1'b0}} : pen_tmr_s;
  end

  // State, entry buffer, timers and registered outputs.
  always_ff @(posedge clk or posedge reset_1) begin
    if (reset_1) begin
      state_r       <= ST_LOCKED;
      buf_r         <= {W{1'b0}};
      cnt_r         <= 4'd0;
      ovf_r         <= 1'b0;
      fail_r        <= 4'd0;
      stored_r      <= DEFAULT_CODE[W-1:0];
      pending_r     <= {W{1'b0}};
      open_tmr_r    <= {OW{1'b0}};
      pen_tmr_r     <= {PW{1'b0}};
      idle_tmr_r    <= {EW{1'b0}};
      lock_open_r   <= 1'b0;
      change_mode_r <= 1'b0;
      penalty_r     <= 1'b0;
      ok_r          <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_s;
      buf_r         <= buf_s;
      cnt_r         <= cnt_s;
      ovf_r         <= ovf_s;
      fail_r        <= fail_s;
      stored_r      <= stored_s;
      pending_r     <= pending_s;
      open_tmr_r    <= open_tmr_s;
      pen_tmr_r     <= pen_tmr_s;
      idle_tmr_r    <= idle_tmr_s;
      lock_open_r   <= (state_s == ST_OPEN);
      change_mode_r <= (state_s == ST_NEW1) || (state_s == ST_NEW2);
      penalty_r     <= (state_s == ST_PENALTY);
      ok_r          <= ok_s;
      err_r         <= err_s;
    end
  end

  assign lock_open   = lock_open_r;
  assign change_mode = change_mode_r;
  assign penalty     = penalty_r;
  assign ok_pulse    = ok_r;
  assign err_pulse   = err_r;
  assign fail_cnt    = fail_r;
  assign digit_cnt   = cnt_r;
  assign disp_data   = buf_r;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Bench for keypad_lock_ctrl: a queue/deadline model of the lock checked every cycle,
// plus directed sequences with hand-computed expectations and a CODE_LEN=6 instance.
module tb_keypad_lock_ctrl;
  localparam int OPEN_N  = 1000;
  localparam int PEN_N   = 5000;
  localparam int ENTRY_N = 3000;
  localparam int LEN     = 4;
  localparam int MAXF    = 3;

  logic clk = 1'b0;
  logic reset_1;
  logic key_valid, key_valid6;
  logic [3:0] key_code, key_code6;
  logic lock_open, change_mode, penalty, ok_pulse, err_pulse;
  logic [3:0] fail_cnt, digit_cnt;
  logic [15:0] disp_data;
  logic lock_open6, change_mode6, penalty6, ok_pulse6, err_pulse6;
  logic [3:0] fail_cnt6, digit_cnt6;
  logic [23:0] disp_data6;
  bit sel6 = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  keypad_lock_ctrl #(.CODE_LEN(LEN), .DEFAULT_CODE(32'h0000_2432), .MAX_FAILS(MAXF),
                     .OPEN_CYC(OPEN_N), .PENALTY_CYC(PEN_N), .ENTRY_CYC(ENTRY_N)) dut (
    .clk(clk), .reset_1(reset_1), .key_valid(key_valid), .key_code(key_code),
    .lock_open(lock_open), .change_mode(change_mode), .penalty(penalty),
    .ok_pulse(ok_pulse), .err_pulse(err_pulse), .fail_cnt(fail_cnt),
    .digit_cnt(digit_cnt), .disp_data(disp_data));

  keypad_lock_ctrl #(.CODE_LEN(6), .DEFAULT_CODE(32'h0012_3456)) dut6 (
    .clk(clk), .reset_1(reset_1), .key_valid(key_valid6), .key_code(key_code6),
    .lock_open(lock_open6), .change_mode(change_mode6), .penalty(penalty6),
    .ok_pulse(ok_pulse6), .err_pulse(err_pulse6), .fail_cnt(fail_cnt6),
    .digit_cnt(digit_cnt6), .disp_data(disp_data6));

  // Model: mode as a name, entry as a digit queue, timers as absolute edge deadlines.
  string  m_mode;
  int     m_dig[$];
  int     m_code[$];
  int     m_pend[$];
  int     m_snap[$];
  bit     m_over, m_ok, m_err, m_active, m_star, m_good, m_hit_code, m_hit_pend;
  int     m_fail;
  longint m_edge, m_last, m_open_end, m_pen_end;

  function automatic bit m_match(input int q[$]);
    if (q.size() != m_dig.size()) return 1'b0;
    foreach (q[i]) if (q[i] != m_dig[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] m_disp();
    logic [15:0] v = 16'h0;
    foreach (m_dig[i]) v = (v << 4) | 16'(m_dig[i]);
    return v;
  endfunction

  task automatic m_goto(input string s);
    if (s != m_mode) begin
      m_mode = s;
      m_dig.delete();
      m_over = 1'b0;
      m_last = m_edge;
      m_open_end = m_edge + OPEN_N;
      m_pen_end = m_edge + PEN_N;
    end
  endtask

  always @(posedge clk or posedge reset_1) begin
    if (reset_1) begin
      m_mode = "LOCKED"; m_dig.delete(); m_over = 1'b0; m_code = '{2, 4, 3, 2};
      m_pend.delete(); m_fail = 0; m_edge = 0; m_last = 0; m_open_end = 0; m_pen_end = 0;
      m_ok = 1'b0; m_err = 1'b0;
    end else begin
      m_edge++; m_ok = 1'b0; m_err = 1'b0;
      m_active = (m_dig.size() > 0) || m_mode == "NEW1" || m_mode == "NEW2";
      if (m_mode == "PENALTY" && m_edge == m_pen_end) begin
        m_goto("LOCKED"); m_fail = 0;
      end else if (m_mode == "OPEN" && m_edge == m_open_end) begin
        m_goto("LOCKED");
      end else if (m_active && m_edge == m_last + ENTRY_N) begin
        m_dig.delete(); m_over = 1'b0; m_last = m_edge;
        if (m_mode == "NEW1" || m_mode == "NEW2") m_goto("LOCKED");
      end else if (key_valid && int'(key_code) <= 11 && m_mode != "PENALTY") begin
        m_last = m_edge;
        if (int'(key_code) <= 9) begin
          if (m_dig.size() == LEN) m_over = 1'b1;
          else m_dig.push_back(int'(key_code));
        end else begin
          m_star = (key_code == 4'hB);
          m_good = (m_dig.size() == LEN) && !m_over;
          m_hit_code = m_good && m_match(m_code);
          m_hit_pend = m_good && m_match(m_pend);
          m_snap = m_dig;
          m_dig.delete(); m_over = 1'b0;
          if (m_mode == "LOCKED") begin
            if (m_hit_code) begin
              m_ok = 1'b1; m_fail = 0; m_goto(m_star ? "NEW1" : "OPEN");
            end else begin
              m_err = 1'b1; m_fail = (m_fail >= 15) ? 15 : m_fail + 1;
              if (m_fail == MAXF) m_goto("PENALTY");
            end
          end else if (m_mode == "OPEN") begin
            if (!m_star) m_goto("LOCKED");
          end else if (m_mode == "NEW1") begin
            if (m_star) m_goto("LOCKED");
            else if (m_good) begin m_pend = m_snap; m_goto("NEW2"); end
            else m_err = 1'b1;
          end else if (m_mode == "NEW2") begin
            if (m_star) m_goto("LOCKED");
            else if (m_hit_pend) begin m_code = m_pend; m_ok = 1'b1; m_goto("LOCKED"); end
            else begin m_err = 1'b1; m_goto("NEW1"); end
          end
        end
      end
    end
  end

  // Every-cycle comparison of the default instance against the model.
  always @(negedge clk) begin
    logic [28:0] got, exp;
    got = {lock_open, change_mode, penalty, ok_pulse, err_pulse, fail_cnt, digit_cnt, disp_data};
    exp = {m_mode == "OPEN", m_mode == "NEW1" || m_mode == "NEW2", m_mode == "PENALTY",
           m_ok, m_err, 4'(m_fail), 4'(m_dig.size()), m_disp()};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model_cycle t=%0t: got %h, expected %h", $time, got, exp);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_valid  = !sel6;
    key_valid6 = sel6;
    key_code   = c;
    key_code6  = c;
  endtask

  task automatic rel();
    @(negedge clk);
    key_valid  = 1'b0;
    key_valid6 = 1'b0;
  endtask

  task automatic seq4(input logic [3:0] a, b, c, d, t);
    press(a); press(b); press(c); press(d); press(t); rel();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] pen_keys [5];
    pen_keys = '{4'd2, 4'd4, 4'd3, 4'd2, 4'hA};
    reset_1 = 1'b0; key_valid = 1'b0; key_valid6 = 1'b0; key_code = 4'h0; key_code6 = 4'h0;
    #1 reset_1 = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {lock_open, change_mode, penalty, ok_pulse, err_pulse}, 5'b0);
    chk("reset_counts", {fail_cnt, digit_cnt, disp_data}, 24'h0);
    reset_1 = 1'b0;

    // Correct default code opens for exactly OPEN_N cycles.
    press(4'd2); press(4'd4); press(4'd3); press(4'd2); rel();
    chk("entry_cnt", digit_cnt, 4'd4);
    chk("entry_disp", disp_data, 16'h2432);
    press(4'hA); rel();
    chk("open_rise", lock_open, 1'b1);
    chk("open_ok", ok_pulse, 1'b1);
    chk("open_cnt_clr", digit_cnt, 4'd0);
    chk("model_open", m_mode == "OPEN", 1'b1);
    n = 0;
    while (lock_open === 1'b1 && n < 1100) begin n++; @(negedge clk); end
    chk("open_len", n, OPEN_N);

    // Overflow and two more failures reach the lockout.
    press(4'd2); press(4'd4); press(4'd3); press(4'd2); press(4'd2); press(4'hA); rel();
    chk("ovf_err", err_pulse, 1'b1);
    chk("ovf_fail", fail_cnt, 4'd1);
    seq4(4'd1, 4'd2, 4'd3, 4'd4, 4'hA);
    chk("fail2", fail_cnt, 4'd2);
    press(4'hB); rel();
    chk("fail3", fail_cnt, 4'd3);
    chk("pen_rise", penalty, 1'b1);
    chk("model_fail", m_fail, 3);
    n = 0;
    while (penalty === 1'b1 && n < 6000) begin
      n++;
      if (n >= 10 && n < 15) begin key_valid = 1'b1; key_code = pen_keys[n-10]; end
      else key_valid = 1'b0;
      @(negedge clk);
    end
    chk("pen_len", n, PEN_N);
    chk("pen_exit_fail", fail_cnt, 4'd0);
    chk("pen_keys_ignored", lock_open, 1'b0);

    // Code change to 1111.
    seq4(4'd2, 4'd4, 4'd3, 4'd2, 4'hB);
    chk("chg_enter", change_mode, 1'b1);
    chk("chg_ok", ok_pulse, 1'b1);
    seq4(4'd1, 4'd1, 4'd1, 4'd1, 4'hA);
    chk("chg_new1", {change_mode, ok_pulse, err_pulse}, 3'b100);
    seq4(4'd1, 4'd1, 4'd1, 4'd1, 4'hA);
    chk("chg_done", {change_mode, ok_pulse, err_pulse}, 3'b010);
    seq4(4'd1, 4'd1, 4'd1, 4'd1, 4'hA);
    chk("new_code_opens", lock_open, 1'b1);
    press(4'hA); rel();
    chk("relock", lock_open, 1'b0);
    seq4(4'd2, 4'd4, 4'd3, 4'd2, 4'hA);
    chk("old_code_err", err_pulse, 1'b1);
    chk("old_code_fail", fail_cnt, 4'd1);

    // Confirm mismatch, invalid entry in NEW1, cancel keeps the code.
    seq4(4'd1, 4'd1, 4'd1, 4'd1, 4'hB);
    chk("new1_fail_clr", fail_cnt, 4'd0);
    press(4'd1); press(4'd2); press(4'hA); rel();
    chk("new1_short_err", {change_mode, err_pulse, fail_cnt}, 6'b110000);
    seq4(4'd2, 4'd2, 4'd2, 4'd2, 4'hA);
    seq4(4'd1, 4'd1, 4'd1, 4'd2, 4'hA);
    chk("confirm_mismatch", {change_mode, err_pulse}, 2'b11);
    press(4'hB); rel();
    chk("cancel", {change_mode, ok_pulse, err_pulse}, 3'b000);
    seq4(4'd1, 4'd1, 4'd1, 4'd1, 4'hA);
    chk("code_kept", lock_open, 1'b1);
    press(4'hA); rel();
    seq4(4'd1, 4'd1, 4'd1, 4'd1, 4'hB);
    n = 0;
    while (change_mode === 1'b1 && n < 4000) begin n++; @(negedge clk); end
    chk("new1_timeout", n, ENTRY_N);

    // Entry timeout leaves fail_cnt alone and wins over a key on the expiry cycle.
    press(4'd9); press(4'hA); rel();
    press(4'd7); rel();
    chk("to_digit", digit_cnt, 4'd1);
    n = 0;
    while (digit_cnt !== 4'd0 && n < 4000) begin n++; @(negedge clk); end
    chk("to_len", n, ENTRY_N);
    chk("to_fail_kept", fail_cnt, 4'd1);
    press(4'd7); rel();
    repeat (ENTRY_N - 1) @(negedge clk);
    key_valid = 1'b1; key_code = 4'd5;
    @(negedge clk);
    key_valid = 1'b0;
    chk("to_key_discard", {digit_cnt, disp_data}, 20'h0);
    press(4'd5); rel();
    chk("after_to_digit", {digit_cnt, disp_data}, 20'h10005);
    press(4'hB); rel();

    // Asynchronous reset while open, after the code change.
    seq4(4'd1, 4'd1, 4'd1, 4'd1, 4'hA);
    chk("pre_reset_open", lock_open, 1'b1);
    repeat (3) @(negedge clk);
    #2 reset_1 = 1'b1;
    #1 chk("async_reset", {lock_open, change_mode, penalty, ok_pulse, err_pulse,
                           fail_cnt, digit_cnt, disp_data}, 29'h0);
    @(negedge clk);
    reset_1 = 1'b0;
    seq4(4'd2, 4'd4, 4'd3, 4'd2, 4'hA);
    chk("default_restored", {lock_open, ok_pulse}, 2'b11);
    press(4'hA); rel();

    // Six-digit instance.
    sel6 = 1'b1;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5); press(4'd6); rel();
    chk("len6_cnt", digit_cnt6, 4'd6);
    chk("len6_disp", disp_data6, 24'h123456);
    press(4'hA); rel();
    chk("len6_open", {lock_open6, ok_pulse6}, 2'b11);
    press(4'hA); rel();
    chk("len6_relock", lock_open6, 1'b0);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5); press(4'hA); rel();
    chk("len6_short_err", {err_pulse6, fail_cnt6, lock_open6}, 6'b100010);
    sel6 = 1'b0;

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
